// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a hold time and PLL lock, then releases
// rst_stage[0..NSTAGES-1] one by one; a debounced button or lock loss restarts it.
module reset_sequencer #(
    parameter int NSTAGES       = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 16,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_n,
    input  logic               pll_locked,
    output logic [NSTAGES-1:0] rst_stage,
    output logic               ready
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W  = $clog2(NSTAGES + 1);

    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DLY_W-1:0]         DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NSTAGES - 1);
    localparam logic [HOLD_W-1:0]        HOLD_ONE  = HOLD_W'(1);
    localparam logic [DLY_W-1:0]         DLY_ONE   = DLY_W'(1);
    localparam logic [IDX_W-1:0]         IDX_ONE   = IDX_W'(1);
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE    = DEBOUNCE_BITS'(1);

    localparam logic [1:0] S_HOLD      = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_RELEASE   = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic [SYNC_STAGES-1:0]   btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0]   lock_sync_q, lock_sync_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
    logic                     btn_db_q, btn_db_d;
    logic [1:0]               state_q, state_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [DLY_W-1:0]         dly_q, dly_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NSTAGES-1:0]       rst_stage_q, rst_stage_d;
    logic                     ready_q, ready_d;

    logic btn_s, lock_s, abort, to_hold;

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign abort  = btn_db_q | ~lock_s;

    always_comb begin
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], ~btn_n};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    // Debounce: the synchronized button must disagree with btn_db for 2^DEBOUNCE_BITS cycles.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (&db_cnt_q) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = '0;
        dly_d       = '0;
        idx_d       = idx_q;
        rst_stage_d = rst_stage_q;
        ready_d     = ready_q;
        to_hold     = 1'b0;
        case (state_q)
            S_HOLD: begin
                rst_stage_d = '1;
                ready_d     = 1'b0;
                idx_d       = '0;
                if (!btn_db_q) begin
                    hold_d = hold_q + HOLD_ONE;
                    if (hold_q == HOLD_LAST) state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (btn_db_q) begin
                    to_hold = 1'b1;
                end else if (lock_s) begin
                    state_d = S_RELEASE;
                    idx_d   = '0;
                end
            end
            S_RELEASE: begin
                // Abort wins over a release falling on the same edge.
                if (abort) begin
                    to_hold = 1'b1;
                end else if (dly_q == DLY_LAST) begin
                    for (int i = 0; i < NSTAGES; i++) begin
                        if (idx_q == IDX_W'(i)) rst_stage_d[i] = 1'b0;
                    end
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    dly_d = dly_q + DLY_ONE;
                end
            end
            default: begin
                if (abort) to_hold = 1'b1;
            end
        endcase
        if (to_hold) begin
            state_d     = S_HOLD;
            hold_d      = '0;
            dly_d       = '0;
            idx_d       = '0;
            rst_stage_d = '1;
            ready_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
            db_cnt_q    <= '0;
            btn_db_q    <= 1'b0;
            state_q     <= S_HOLD;
            hold_q      <= '0;
            dly_q       <= '0;
            idx_q       <= '0;
            rst_stage_q <= '1;
            ready_q     <= 1'b0;
        end else begin
            btn_sync_q  <= btn_sync_d;
            lock_sync_q <= lock_sync_d;
            db_cnt_q    <= db_cnt_d;
            btn_db_q    <= btn_db_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            dly_q       <= dly_d;
            idx_q       <= idx_d;
            rst_stage_q <= rst_stage_d;
            ready_q     <= ready_d;
        end
    end

    assign rst_stage = rst_stage_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed stimulus queues per-edge
// expectations; a negedge monitor and an immediate-check monitor compare them.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_n;
    logic       pll_locked;
    logic [2:0] rst_stage;
    logic       ready;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NSTAGES      (3),
        .SYNC_STAGES  (2),
        .DEBOUNCE_BITS(2),
        .HOLD_CYCLES  (4),
        .STAGE_DELAY  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_n     (btn_n),
        .pll_locked(pll_locked),
        .rst_stage (rst_stage),
        .ready     (ready)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [2:0] st;
        logic       rdy;
        logic       db;
    } exp_t;

    exp_t sb_q[$];
    exp_t now_q[$];
    event now_ev;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   base     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input exp_t e);
        checks++;
        if (rst_stage !== e.st || ready !== e.rdy || dut.btn_db_q !== e.db) begin
            failures++;
            $display("FAIL %s edge=%0d got rst_stage=%b ready=%b btn_db=%b want rst_stage=%b ready=%b btn_db=%b",
                     e.name, e.cyc - base, rst_stage, ready, dut.btn_db_q, e.st, e.rdy, e.db);
        end
    endtask

    // Edge-tagged monitor: sampled half a cycle after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missed sample at edge %0d", e.name, e.cyc - base);
                end else begin
                    compare(e);
                end
            end
        end
    end

    // Immediate monitor for checks that must hold between clock edges.
    initial begin
        exp_t e;
        forever begin
            @(now_ev);
            while (now_q.size() > 0) begin
                e = now_q.pop_front();
                compare(e);
            end
        end
    end

    task automatic exp_range(input string nm, input int k0, input int k1,
                             input logic [2:0] st, input logic rdy, input logic db);
        exp_t e;
        for (int k = k0; k <= k1; k++) begin
            e.name = nm; e.cyc = base + k; e.st = st; e.rdy = rdy; e.db = db;
            sb_q.push_back(e);
        end
    endtask

    task automatic exp_now(input string nm, input logic [2:0] st, input logic rdy, input logic db);
        exp_t e;
        e.name = nm; e.cyc = cyc; e.st = st; e.rdy = rdy; e.db = db;
        now_q.push_back(e);
        ->now_ev;
        #1;
    endtask

    // Returns just after edge k (edge numbering relative to the last reset release).
    task automatic after_edge(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_now("reset_state", 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        base  = cyc;
    endtask

    initial begin
        reset      = 1'b1;
        btn_n      = 1'b1;
        pll_locked = 1'b1;

        // Nominal: WAIT_LOCK at 4, RELEASE at 5, stages fall at 8, 11, 14.
        do_reset();
        exp_range("nominal_hold", 1, 7, 3'b111, 1'b0, 1'b0);
        exp_range("nominal_s0", 8, 10, 3'b110, 1'b0, 1'b0);
        exp_range("nominal_s1", 11, 13, 3'b100, 1'b0, 1'b0);
        exp_range("nominal_run", 14, 16, 3'b000, 1'b1, 1'b0);
        after_edge(17);

        // Late lock: pll_locked captured at edge 11, lock_s high after edge 12,
        // FSM leaves WAIT_LOCK at edge 13, stages fall at 16, 19, 22.
        pll_locked = 1'b0;
        do_reset();
        exp_range("late_lock_wait", 1, 15, 3'b111, 1'b0, 1'b0);
        exp_range("late_lock_s0", 16, 18, 3'b110, 1'b0, 1'b0);
        exp_range("late_lock_s1", 19, 21, 3'b100, 1'b0, 1'b0);
        exp_range("late_lock_run", 22, 24, 3'b000, 1'b1, 1'b0);
        after_edge(10);
        pll_locked = 1'b1;
        after_edge(25);

        // Bounce (2-cycle press from edge 16) then a held press from edge 30,
        // released after edge 40: btn_db high for edges 36..45, sequence restarts.
        do_reset();
        exp_range("btn_seq_hold", 1, 7, 3'b111, 1'b0, 1'b0);
        exp_range("btn_seq_s0", 8, 10, 3'b110, 1'b0, 1'b0);
        exp_range("btn_seq_s1", 11, 13, 3'b100, 1'b0, 1'b0);
        exp_range("bounce_run", 14, 35, 3'b000, 1'b1, 1'b0);
        exp_range("press_db", 36, 36, 3'b000, 1'b1, 1'b1);
        exp_range("press_hold", 37, 45, 3'b111, 1'b0, 1'b1);
        exp_range("unpress_hold", 46, 53, 3'b111, 1'b0, 1'b0);
        exp_range("repeat_s0", 54, 56, 3'b110, 1'b0, 1'b0);
        exp_range("repeat_s1", 57, 59, 3'b100, 1'b0, 1'b0);
        exp_range("repeat_run", 60, 62, 3'b000, 1'b1, 1'b0);
        after_edge(16);
        btn_n = 1'b0;
        after_edge(18);
        btn_n = 1'b1;
        after_edge(30);
        btn_n = 1'b0;
        after_edge(40);
        btn_n = 1'b1;
        after_edge(63);

        // Lock loss after stage 0: abort at edge 11 beats the stage-1 release;
        // lock back after edge 20 -> RELEASE at 23, stages fall at 26, 29, 32.
        do_reset();
        exp_range("lockloss_hold", 1, 7, 3'b111, 1'b0, 1'b0);
        exp_range("lockloss_s0", 8, 10, 3'b110, 1'b0, 1'b0);
        exp_range("lockloss_abort", 11, 25, 3'b111, 1'b0, 1'b0);
        exp_range("relock_s0", 26, 28, 3'b110, 1'b0, 1'b0);
        exp_range("relock_s1", 29, 31, 3'b100, 1'b0, 1'b0);
        exp_range("relock_run", 32, 35, 3'b000, 1'b1, 1'b0);
        after_edge(8);
        pll_locked = 1'b0;
        after_edge(20);
        pll_locked = 1'b1;
        after_edge(36);

        // Asynchronous reset between edges while in RUN.
        #2;
        reset = 1'b1;
        #1;
        exp_now("async_reset", 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
